// File: rtl/pflink_pkg.sv
// pflink shared definitions: framing characters, K-patterns, word/FSM types
// and the frame header builder used by the TX scheduler.
package pflink_pkg;

  localparam logic [7:0] COMMA_CHAR = 8'hBC;
  localparam logic [7:0] IDLE_CHAR  = 8'hF7;
  localparam logic [7:0] PAD_CHAR   = 8'h00;
  localparam logic [7:0] HDR_MAGIC  = 8'hA5;

  localparam logic [1:0] K_COMMA = 2'b01;
  localparam logic [1:0] K_DATA  = 2'b00;
  localparam logic [1:0] K_IDLE  = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_COMMA = 2'd1,
    W_DATA  = 2'd2
  } word_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  // Header word: magic, owning requester (zero-padded to a nibble), frame number.
  function automatic logic [31:0] make_hdr(input logic [1:0] grant, input logic [15:0] fnum);
    return {HDR_MAGIC, 2'b00, 2'b00, grant, 2'b00, fnum};
  endfunction

endpackage

// File: rtl/pflink_rr_arb.sv
// Combinational round-robin search: first asserted request at or above the
// pointer, wrapping modulo NUM_REQ.
module pflink_rr_arb
  import pflink_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [1:0]         grant_o,
  output logic               found_o
);

  logic [3:0] req4;
  logic [2:0] scan_idx;

  assign req4 = 4'(req_i);

  // Walk NUM_REQ slots starting at the pointer; the first hit wins.
  always_comb begin
    grant_o  = '0;
    found_o  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_i} + 3'(k);
      if (scan_idx >= 3'(NUM_REQ)) scan_idx = scan_idx - 3'(NUM_REQ);
      if (!found_o && req4[scan_idx[1:0]]) begin
        found_o = 1'b1;
        grant_o = scan_idx[1:0];
      end
    end
  end

endmodule

// File: rtl/pflink_tx_sched.sv
// pflink TX scheduler: round-robin frame arbitration, 32->16 bit
// serialisation, periodic/forced comma insertion and IDLE fill.
// Optional build macro PFLINK_TX_HDR_EN prefixes every frame with a header word.
//
//   state   | meaning
//   S_IDLE  | no grant held; a boundary may start a new frame
//   S_FRAME | grant locked to one requester until its last word
module pflink_tx_sched
  import pflink_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int COMMA_PERIOD = 64
) (
  input  logic                   clk_link,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   force_comma,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            tx_d,
  output logic [1:0]             tx_k,
  output logic                   busy,
  output logic [31:0]            frame_count,
  output logic [31:0]            comma_count
);

  localparam int CW = $clog2(COMMA_PERIOD);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(COMMA_PERIOD - 1);

  state_t        state_q, state_d;
  logic          phase_q;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   frames_q, frames_d;
  logic [31:0]   commas_q, commas_d;
  logic [15:0]   txd_q, txd_d, hid_q, hid_d;
  logic [1:0]    txk_q, txk_d, hik_q, hik_d;

  logic          boundary, comma_due;
  logic [1:0]    arb_grant, sel;
  logic          arb_found, rdy_en;
  word_t         wtype;
  logic [31:0]   word;
  logic [3:0]    valid4, last4;
  logic [31:0]   word4 [4];

  // Pad per-requester inputs to four slots so a 2-bit index is always legal.
  assign valid4 = 4'(req_valid);
  assign last4  = 4'(req_last);
  for (genvar i = 0; i < 4; i++) begin : g_pad
    if (i < NUM_REQ) begin : g_real
      assign word4[i] = req_data[32*i +: 32];
    end else begin : g_zero
      assign word4[i] = '0;
    end
  end

  assign boundary  = ~phase_q;
  assign comma_due = (cnt_q == '0) | pend_q;

  pflink_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .found_o (arb_found)
  );

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    return (int'(g) == NUM_REQ - 1) ? 2'd0 : g + 2'd1;
  endfunction

  // Word-boundary decision: comma beats data beats IDLE; FSM next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | force_comma;
    frames_d = frames_q;
    commas_d = commas_q;
    wtype    = W_IDLE;
    word     = '0;
    rdy_en   = 1'b0;
    sel      = (state_q == S_IDLE) ? arb_grant : grant_q;
    if (boundary) begin
      if (comma_due) begin
        wtype    = W_COMMA;
        cnt_d    = CNT_RELOAD;
        pend_d   = 1'b0;
        commas_d = commas_q + 32'd1;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        case (state_q)
          S_IDLE: begin
            if (enable && arb_found) begin
              grant_d = arb_grant;
`ifdef PFLINK_TX_HDR_EN
              wtype   = W_DATA;
              word    = make_hdr(arb_grant, frames_q[15:0]);
              state_d = S_FRAME;
`else
              rdy_en  = 1'b1;
              wtype   = W_DATA;
              word    = word4[arb_grant];
              if (last4[arb_grant]) begin
                frames_d = frames_q + 32'd1;
                rr_d     = rr_next(arb_grant);
              end else begin
                state_d = S_FRAME;
              end
`endif
            end
          end
          S_FRAME: begin
            // A missing word inside a frame is a stall: send IDLE, keep the grant.
            if (valid4[grant_q]) begin
              rdy_en = 1'b1;
              wtype  = W_DATA;
              word   = word4[grant_q];
              if (last4[grant_q]) begin
                frames_d = frames_q + 32'd1;
                rr_d     = rr_next(grant_q);
                state_d  = S_IDLE;
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // One-hot ready for the selected requester.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rdy_en && (sel == 2'(i));
    end
  end

  // Serialiser: half0 is launched at the boundary, half1 is held for the next cycle.
  always_comb begin
    txd_d = hid_q;
    txk_d = hik_q;
    hid_d = hid_q;
    hik_d = hik_q;
    if (boundary) begin
      case (wtype)
        W_COMMA: begin
          txd_d = {PAD_CHAR, COMMA_CHAR};
          txk_d = K_COMMA;
          hid_d = {IDLE_CHAR, IDLE_CHAR};
          hik_d = K_IDLE;
        end
        W_DATA: begin
          txd_d = word[15:0];
          txk_d = K_DATA;
          hid_d = word[31:16];
          hik_d = K_DATA;
        end
        default: begin
          txd_d = {IDLE_CHAR, IDLE_CHAR};
          txk_d = K_IDLE;
          hid_d = {IDLE_CHAR, IDLE_CHAR};
          hik_d = K_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset forces a comma as the first word.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      grant_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      frames_q <= '0;
      commas_q <= '0;
      txd_q    <= {IDLE_CHAR, IDLE_CHAR};
      txk_q    <= K_IDLE;
      hid_q    <= {IDLE_CHAR, IDLE_CHAR};
      hik_q    <= K_IDLE;
    end else begin
      state_q  <= state_d;
      phase_q  <= ~phase_q;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      frames_q <= frames_d;
      commas_q <= commas_d;
      txd_q    <= txd_d;
      txk_q    <= txk_d;
      hid_q    <= hid_d;
      hik_q    <= hik_d;
    end
  end

  assign tx_d        = txd_q;
  assign tx_k        = txk_q;
  assign busy        = (state_q == S_FRAME);
  assign frame_count = frames_q;
  assign comma_count = commas_q;

endmodule

// File: tb/tb_pflink_tx_sched.sv
// Bench for pflink_tx_sched (default build, NUM_REQ=2, COMMA_PERIOD=4).
module tb_pflink_tx_sched;

  localparam int NR = 2;
  localparam int CP = 4;

  logic            clk_link = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            force_comma = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [32*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [15:0]     tx_d;
  logic [1:0]      tx_k;
  logic            busy;
  logic [31:0]     frame_count;
  logic [31:0]     comma_count;

  always #5 clk_link = ~clk_link;

  pflink_tx_sched #(.NUM_REQ(NR), .COMMA_PERIOD(CP)) dut (
    .clk_link    (clk_link),
    .reset       (reset),
    .enable      (enable),
    .force_comma (force_comma),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_d        (tx_d),
    .tx_k        (tx_k),
    .busy        (busy),
    .frame_count (frame_count),
    .comma_count (comma_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: what each boundary sends, and which half is on the wire.
  int          m_phase, m_cnt, m_owner, m_rr, m_pend, m_in_frame;
  logic [31:0] m_frames, m_commas;
  logic [15:0] m_txd, m_hid;
  logic [1:0]  m_txk, m_hik;
  bit          hs;
  int          hs_idx;
  logic [15:0] dq[$];

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_owner = 0; m_rr = 0; m_pend = 0; m_in_frame = 0;
    m_frames = 0; m_commas = 0;
    m_txd = 16'hF7F7; m_txk = 2'b11; m_hid = 16'hF7F7; m_hik = 2'b11;
  endtask

  function automatic int m_pick(input logic [NR-1:0] v, input logic en);
    if (m_phase != 0 || m_cnt == 0 || m_pend != 0) return -1;
    if (m_in_frame != 0) return v[m_owner] ? m_owner : -1;
    if (!en) return -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: compare everything at the falling edge, then advance the model.
  task automatic step();
    int pick, np;
    logic [NR-1:0]    rexp;
    logic             c_rst, c_force;
    logic [32*NR-1:0] c_data;
    logic [NR-1:0]    c_last;
    logic [31:0]      w;
    @(negedge clk_link);
    pick = m_pick(req_valid, enable);
    rexp = '0;
    if (pick >= 0) rexp[pick] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(rexp));
    chk("tx_d", 32'(tx_d), 32'(m_txd));
    chk("tx_k", 32'(tx_k), 32'(m_txk));
    chk("busy", 32'(busy), 32'(m_in_frame));
    chk("frame_count", frame_count, m_frames);
    chk("comma_count", comma_count, m_commas);
    if (tx_k == 2'b00) dq.push_back(tx_d);
    hs = (pick >= 0);
    hs_idx = pick;
    c_rst = reset; c_force = force_comma; c_data = req_data; c_last = req_last;
    @(posedge clk_link);
    if (c_rst) m_reset();
    else begin
      np = (m_pend != 0 || c_force) ? 1 : 0;
      if (m_phase == 0) begin
        if (m_cnt == 0 || m_pend != 0) begin
          m_txd = 16'h00BC; m_txk = 2'b01; m_hid = 16'hF7F7; m_hik = 2'b11;
          m_cnt = CP - 1; m_commas++; np = 0;
        end else begin
          m_cnt--;
          if (pick >= 0) begin
            w = c_data[32*pick +: 32];
            m_txd = w[15:0]; m_txk = 2'b00; m_hid = w[31:16]; m_hik = 2'b00;
            if (c_last[pick]) begin
              m_frames++; m_rr = (pick + 1) % NR; m_in_frame = 0;
            end else begin
              m_in_frame = 1; m_owner = pick;
            end
          end else begin
            m_txd = 16'hF7F7; m_txk = 2'b11; m_hid = 16'hF7F7; m_hik = 2'b11;
          end
        end
      end else begin
        m_txd = m_hid; m_txk = m_hik;
      end
      m_pend = np;
      m_phase = 1 - m_phase;
    end
    #1;
  endtask

  task automatic run_until_hs(input string nm);
    int t;
    t = 0;
    hs = 1'b0;
    while (!hs && t < 40) begin
      step();
      t++;
    end
    chk(nm, 32'(hs), 32'd1);
  endtask

  typedef struct {
    logic          en;
    logic [NR-1:0] valid;
    logic [NR-1:0] rdy;
    logic [15:0]   d;
    logic [1:0]    k;
  } vec_t;

  vec_t tab[16];

  initial begin
    int prev, ngrants, n;
    logic [31:0] c0, f0;
    logic [15:0] fexp[4];

    // Idle line after reset: comma, then three IDLE words, repeating.
    for (int i = 0; i < 16; i++) begin
      tab[i].en    = (i < 8);
      tab[i].valid = (i < 8) ? 2'b00 : 2'b11;
      tab[i].rdy   = 2'b00;
      tab[i].d     = (i % 8 == 0) ? 16'h00BC : 16'hF7F7;
      tab[i].k     = (i % 8 == 0) ? 2'b01 : 2'b11;
    end
    fexp[0] = 16'h2222; fexp[1] = 16'h1111; fexp[2] = 16'h4444; fexp[3] = 16'h3333;

    repeat (2) @(posedge clk_link);
    #1;
    m_reset();
    enable = 1'b1;
    step();
    chk("rst_tx_d", 32'(tx_d), 32'h0000F7F7);
    chk("rst_tx_k", 32'(tx_k), 32'd3);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", frame_count, 32'd0);
    chk("rst_commas", comma_count, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      enable = tab[i].en;
      req_valid = tab[i].valid;
      #1;
      chk("tab_ready", 32'(req_ready), 32'(tab[i].rdy));
      step();
      chk("tab_tx_d", 32'(tx_d), 32'(tab[i].d));
      chk("tab_tx_k", 32'(tx_k), 32'(tab[i].k));
    end
    chk("tab_commas", comma_count, 32'd2);
    enable = 1'b1;
    req_valid = '0;

    // Two-word frame from requester 0.
    dq.delete();
    req_data[31:0] = 32'h11112222; req_last = 2'b00; req_valid = 2'b01;
    run_until_hs("f_w0_hs");
    chk("f_first_half", 32'(tx_d), 32'h00002222);
    req_data[31:0] = 32'h33334444; req_last = 2'b01;
    run_until_hs("f_w1_hs");
    req_valid = '0; req_last = '0;
    repeat (3) step();
    chk("f_halves", dq.size(), 32'd4);
    if (dq.size() >= 4)
      for (int i = 0; i < 4; i++) chk("f_half", 32'(dq[i]), 32'(fexp[i]));
    chk("f_frames", frame_count, 32'd1);

    // Two requesters, one-word frames: grants must alternate.
    req_data = {32'hBBBB0001, 32'hAAAA0000}; req_last = 2'b11; req_valid = 2'b11;
    prev = -1; ngrants = 0;
    for (int t = 0; t < 24; t++) begin
      step();
      if (hs) begin
        if (prev >= 0) chk("alt_no_repeat", 32'(hs_idx == prev), 32'd0);
        prev = hs_idx;
        ngrants++;
      end
    end
    chk("alt_grants", 32'(ngrants >= 6), 32'd1);
    req_valid = '0; req_last = '0;
    step();

    // Ten-word frame with commas interleaved.
    dq.delete();
    c0 = comma_count;
    n = 0;
    req_valid = 2'b01;
    for (int t = 0; t < 200 && n < 10; t++) begin
      req_data[31:0] = {16'hC000 + 16'(n), 16'h5000 + 16'(n)};
      req_last[0] = (n == 9);
      step();
      if (hs) n++;
    end
    req_valid = '0; req_last = '0;
    repeat (3) step();
    chk("w10_words", 32'(n), 32'd10);
    chk("w10_halves", dq.size(), 32'd20);
    if (dq.size() == 20)
      for (int i = 0; i < 10; i++) begin
        chk("w10_lo", 32'(dq[2*i]), 32'h5000 + 32'(i));
        chk("w10_hi", 32'(dq[2*i+1]), 32'hC000 + 32'(i));
      end
    chk("w10_commas", 32'((comma_count - c0) >= 2), 32'd1);

    // force_comma on a phase-1 cycle inside a stalled frame.
    req_data[31:0] = 32'h77776666; req_last = 2'b00; req_valid = 2'b01;
    run_until_hs("fc_start_hs");
    req_valid = '0;
    if (m_cnt == 0) repeat (2) step();
    force_comma = 1'b1;
    step();
    force_comma = 1'b0;
    step();
    chk("fc_comma_d", 32'(tx_d), 32'h000000BC);
    chk("fc_comma_k", 32'(tx_k), 32'd1);
    repeat (2) step();
    chk("fc_clear_d", 32'(tx_d), 32'h0000F7F7);
    chk("fc_clear_k", 32'(tx_k), 32'd3);
    chk("fc_busy", 32'(busy), 32'd1);

    // Stall with enable low: grant held, frame still finishes, no new grant.
    enable = 1'b0;
    repeat (6) begin
      step();
      chk("st_busy", 32'(busy), 32'd1);
      chk("st_k_not_data", 32'(tx_k[0]), 32'd1);
      chk("st_ready", 32'(req_ready), 32'd0);
    end
    f0 = frame_count;
    req_data[31:0] = 32'h99998888; req_last = 2'b01; req_valid = 2'b01;
    run_until_hs("st_resume_hs");
    req_valid = 2'b11; req_last = 2'b11;
    step();
    chk("st_frames", frame_count, f0 + 32'd1);
    repeat (10) begin
      step();
      chk("st_no_grant_busy", 32'(busy), 32'd0);
      chk("st_no_grant_ready", 32'(req_ready), 32'd0);
    end

    // Reset in the middle of a frame: next word is a comma.
    enable = 1'b1; req_valid = 2'b01; req_last = 2'b00;
    run_until_hs("rm_start_hs");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rm_comma_d", 32'(tx_d), 32'h000000BC);
    chk("rm_comma_k", 32'(tx_k), 32'd1);
    chk("rm_frames", frame_count, 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);

    // Random traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      enable = ($urandom_range(0, 9) != 0);
      req_valid = NR'($urandom());
      for (int i = 0; i < NR; i++) begin
        req_last[i] = ($urandom_range(0, 9) < 3);
        req_data[32*i +: 32] = $urandom();
      end
      force_comma = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; force_comma = 1'b0; req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
